// File: rtl/vp_cart_pkg.sv
// vp_cart_pkg
// Shared definitions for the Videopac cartridge controller: loader FSM state
// type, image-size thresholds that select the bank mapping, CRC-32 constants
// and helpers for the byte-serial CRC and the console address mapping.
// The CRC items are only consumed when VP_CART_CRC_EN is defined.

package vp_cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } cart_state_t;

    localparam logic [15:0] SIZE_2K = 16'h0800;
    localparam logic [15:0] SIZE_4K = 16'h1000;
    localparam logic [15:0] SIZE_8K = 16'h2000;

    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    // One byte through the reflected CRC-32 (LSB first).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Console address + bank lines to a 14-bit store index. Bit 10 of the
    // console address is the CPU's internal/external select and is dropped
    // for every image up to 8K.
    function automatic logic [13:0] cart_map(input logic [15:0] size,
                                             input logic [11:0] a,
                                             input logic        bs0,
                                             input logic        bs1);
        if (size <= SIZE_2K)
            return {3'b000, a[11], a[9:0]};
        else if (size <= SIZE_4K)
            return {2'b00, bs0, a[11], a[9:0]};
        else if (size <= SIZE_8K)
            return {1'b0, bs1, bs0, a[11], a[9:0]};
        else
            return {bs1, bs0, a};
    endfunction

endpackage

// File: rtl/vp_cart_crc32.sv
// vp_cart_crc32
// Byte-serial CRC-32 accumulator (reflected 0xEDB88320, init 0xFFFFFFFF).
// Only instantiated when VP_CART_CRC_EN is defined. The result is the raw
// register; the final inversion is left to the consumer.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        reload the init value
//   strobe       fold in one byte this cycle
//   data         byte to fold in
//   crc          running CRC register

module vp_cart_crc32
    import vp_cart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        strobe,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= CRC32_INIT;
        else if (clear)
            crc <= CRC32_INIT;
        else if (strobe)
            crc <= crc32_byte(crc, data);
    end

endmodule

// File: rtl/vp_cart_ctrl.sv
// vp_cart_ctrl
// Cartridge-side responder for the Videopac cartridge bus. Writes downloaded
// images into the cart ROM store, tracks the image size, maps console fetches
// (address + bank-switch lines) onto the store and returns the fetched byte.
// Optional feature macro: VP_CART_CRC_EN adds a CRC-32 of each image on
// cart_crc_o.
// Ports:
//   clk_i, res_n_i           clock, async active-low reset
//   dl_active_i/wr/addr/data download stream (cart-ROM downloads only)
//   cart_a_i, cart_bs0_i/1_i console address and bank-switch lines
//   cart_psen_n_i            program store enable, active-low
//   cart_d_o                 byte returned to the console
//   rom_a_o/we_o/wd_o, rom_d_i  single-port synchronous ROM store
//   cart_size_o              byte count of the last completed image
//   loaded_o                 one-cycle pulse at download completion
//   cart_crc_o               CRC-32 of the last image (VP_CART_CRC_EN only)
//
// state   | meaning
// IDLE    | mapping console fetches, waiting for dl_active_i rise
// LOAD    | accepting download bytes, console output forced to 0xFF
// DONE    | publish size/CRC, pulse loaded_o, back to IDLE

module vp_cart_ctrl
    import vp_cart_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic              dl_active_i,
    input  logic              dl_wr_i,
    input  logic [24:0]       dl_addr_i,
    input  logic [7:0]        dl_data_i,
    input  logic [11:0]       cart_a_i,
    input  logic              cart_bs0_i,
    input  logic              cart_bs1_i,
    input  logic              cart_psen_n_i,
    output logic [7:0]        cart_d_o,
    output logic [ADDR_W-1:0] rom_a_o,
    output logic              rom_we_o,
    output logic [7:0]        rom_wd_o,
    input  logic [7:0]        rom_d_i,
    output logic [15:0]       cart_size_o,
    output logic              loaded_o
`ifdef VP_CART_CRC_EN
    ,
    output logic [31:0]       cart_crc_o
`endif
);

    cart_state_t       state;
    logic              dl_active_q;
    logic [15:0]       byte_cnt;
    logic              psen_d1;
    logic              psen_d2;
    logic              dl_rise;
    logic              dl_fall;
    logic              in_range;
    logic [13:0]       map_idx;
    logic [ADDR_W-1:0] map_a;

    assign dl_rise  = dl_active_i & ~dl_active_q;
    assign dl_fall  = ~dl_active_i & dl_active_q;
    assign in_range = (dl_addr_i[24:ADDR_W] == '0);
    assign map_idx  = cart_map(cart_size_o, cart_a_i, cart_bs0_i, cart_bs1_i);
    assign map_a    = ADDR_W'(map_idx);

`ifdef VP_CART_CRC_EN
    logic        crc_clear;
    logic        crc_strobe;
    logic [31:0] crc_val;

    assign crc_clear  = (state == ST_IDLE) && dl_rise;
    // Out-of-range bytes are still folded into the CRC.
    assign crc_strobe = (state == ST_LOAD) && dl_wr_i;

    vp_cart_crc32 u_crc (
        .clk    (clk_i),
        .rst_n  (res_n_i),
        .clear  (crc_clear),
        .strobe (crc_strobe),
        .data   (dl_data_i),
        .crc    (crc_val)
    );
`endif

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state       <= ST_IDLE;
            dl_active_q <= 1'b0;
            byte_cnt    <= 16'h0000;
            psen_d1     <= 1'b1;
            psen_d2     <= 1'b1;
            rom_a_o     <= '0;
            rom_we_o    <= 1'b0;
            rom_wd_o    <= 8'h00;
            cart_d_o    <= 8'hFF;
            cart_size_o <= 16'h0000;
            loaded_o    <= 1'b0;
`ifdef VP_CART_CRC_EN
            cart_crc_o  <= 32'h00000000;
`endif
        end else begin
            dl_active_q <= dl_active_i;
            psen_d1     <= cart_psen_n_i;
            psen_d2     <= psen_d1;
            rom_we_o    <= 1'b0;
            loaded_o    <= 1'b0;

            // dl_active_i is included so the entry cycle into LOAD is
            // already blanked.
            if (state == ST_LOAD || dl_active_i || psen_d2)
                cart_d_o <= 8'hFF;
            else
                cart_d_o <= rom_d_i;

            case (state)
                ST_IDLE: begin
                    rom_a_o <= map_a;
                    if (dl_rise) begin
                        state    <= ST_LOAD;
                        byte_cnt <= 16'h0000;
                    end
                end
                ST_LOAD: begin
                    if (dl_wr_i) begin
                        if (byte_cnt != 16'hFFFF)
                            byte_cnt <= byte_cnt + 16'h0001;
                        if (in_range) begin
                            rom_a_o  <= dl_addr_i[ADDR_W-1:0];
                            rom_wd_o <= dl_data_i;
                            rom_we_o <= 1'b1;
                        end
                    end
                    if (dl_fall)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    rom_a_o     <= map_a;
                    cart_size_o <= byte_cnt;
                    loaded_o    <= 1'b1;
`ifdef VP_CART_CRC_EN
                    cart_crc_o  <= ~crc_val;
`endif
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vp_cart_ctrl.sv
// Self-checking bench for vp_cart_ctrl. Drives downloads and console fetches,
// models the ROM store, and compares against table vectors and a behavioural
// model (expected image array, size rule, arithmetic bank mapping, CRC).

module tb_vp_cart_ctrl;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = 8'h00;
    logic [11:0] cart_a = 12'h000;
    logic        bs0 = 1'b0;
    logic        bs1 = 1'b0;
    logic        psen_n = 1'b1;
    logic [7:0]  cart_d;
    logic [13:0] rom_a;
    logic        rom_we;
    logic [7:0]  rom_wd;
    logic [7:0]  rom_d = 8'h00;
    logic [15:0] cart_size;
    logic        loaded;
`ifdef VP_CART_CRC_EN
    logic [31:0] cart_crc;
`endif

    vp_cart_ctrl #(.ADDR_W(14)) dut (
        .clk_i         (clk),
        .res_n_i       (res_n),
        .dl_active_i   (dl_active),
        .dl_wr_i       (dl_wr),
        .dl_addr_i     (dl_addr),
        .dl_data_i     (dl_data),
        .cart_a_i      (cart_a),
        .cart_bs0_i    (bs0),
        .cart_bs1_i    (bs1),
        .cart_psen_n_i (psen_n),
        .cart_d_o      (cart_d),
        .rom_a_o       (rom_a),
        .rom_we_o      (rom_we),
        .rom_wd_o      (rom_wd),
        .rom_d_i       (rom_d),
        .cart_size_o   (cart_size),
        .loaded_o      (loaded)
`ifdef VP_CART_CRC_EN
        ,
        .cart_crc_o    (cart_crc)
`endif
    );

    always #5 clk = ~clk;

    // ROM store model
    logic [7:0] mem [0:16383];
    always @(posedge clk) begin
        if (rom_we === 1'b1) mem[rom_a] <= rom_wd;
        rom_d <= mem[rom_a];
    end

    int we_total = 0;
    int loaded_total = 0;
    always @(posedge clk) begin
        if (rom_we === 1'b1) we_total++;
        if (loaded === 1'b1) loaded_total++;
    end

    // Reference model state
    logic [7:0] exp_img [0:16383];
    logic [7:0] bq [$];
    int model_size = 0;
    int exp_writes = 0;
    int we_base = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] a;
        logic        b0;
        logic        b1;
        logic [13:0] exp_a;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t tbl2k [6];
    vec_t tbl8k [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_map(input int s, input int a, input int b0, input int b1);
        int low = a % 1024;
        int a11 = (a / 2048) % 2;
        if (s <= 2048)      return a11 * 1024 + low;
        else if (s <= 4096) return b0 * 2048 + a11 * 1024 + low;
        else if (s <= 8192) return b1 * 4096 + b0 * 2048 + a11 * 1024 + low;
        else                return b1 * 8192 + b0 * 4096 + (a % 4096);
    endfunction

    function automatic logic [31:0] model_crc();
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (bq[k]) begin
            c = c ^ {24'h0, bq[k]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic dl_start();
        bq.delete();
        exp_writes = 0;
        we_base = we_total;
        psen_n = 1'($urandom_range(0, 1));
        cart_a = 12'($urandom_range(0, 4095));
        dl_active = 1'b1;
        tick();
        tick();
        check("cart_d_load_start", 32'(cart_d), 32'hFF);
    endtask

    task automatic send_one(input int ad, input logic [7:0] d, input bit fall, input bit first);
        dl_addr = 25'(ad);
        dl_data = d;
        dl_wr = 1'b1;
        if (fall) dl_active = 1'b0;
        bq.push_back(d);
        if (ad < 16384) begin
            exp_img[ad] = d;
            exp_writes++;
        end
        tick();
        dl_wr = 1'b0;
        if (first && ad < 16384) begin
            check("wr_we", 32'(rom_we), 32'h1);
            check("wr_addr", 32'(rom_a), 32'(ad));
            check("wr_data", 32'(rom_wd), 32'(d));
        end
    endtask

    task automatic send_bytes(input int first, input int n, input bit rnd, input bit gaps, input bit simul);
        for (int i = 0; i < n; i++) begin
            int ad = first + i;
            logic [7:0] d = rnd ? 8'($urandom) : 8'(ad);
            send_one(ad, d, simul && (i == n - 1), i == 0);
            if (i % 1024 == 1023) check("cart_d_in_load", 32'(cart_d), 32'hFF);
            if (gaps && i < n - 1 && $urandom_range(0, 3) == 0) tick();
        end
    endtask

    task automatic end_dl(input bit simul);
        if (!simul) begin
            dl_active = 1'b0;
            tick();
        end
        check("loaded_before", 32'(loaded), 32'h0);
        tick();
        check("loaded_pulse", 32'(loaded), 32'h1);
        check("we_idle", 32'(rom_we), 32'h0);
        tick();
        check("loaded_after", 32'(loaded), 32'h0);
        model_size = (bq.size() > 65535) ? 65535 : bq.size();
        check("cart_size", 32'(cart_size), 32'(model_size));
        check("write_count", 32'(we_total - we_base), 32'(exp_writes));
`ifdef VP_CART_CRC_EN
        check("cart_crc", cart_crc, model_crc());
`endif
        psen_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic fetch(input logic [11:0] a, input logic b0, input logic b1,
                         input logic [13:0] ea, input logic [7:0] ed);
        cart_a = a;
        bs0 = b0;
        bs1 = b1;
        psen_n = 1'b0;
        tick();
        check("fetch_addr", 32'(rom_a), 32'(ea));
        tick();
        tick();
        check("fetch_data", 32'(cart_d), 32'(ed));
        psen_n = 1'b1;
        tick();
        tick();
        tick();
        check("psen_release", 32'(cart_d), 32'hFF);
    endtask

    task automatic random_fetches(input int n);
        for (int k = 0; k < n; k++) begin
            int a = $urandom_range(0, 4095);
            int b0 = $urandom_range(0, 1);
            int b1 = $urandom_range(0, 1);
            int idx = model_map(model_size, a, b0, b1);
            fetch(12'(a), 1'(b0), 1'(b1), 14'(idx), exp_img[idx]);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        string s9;
        int bad;

        tbl2k[0] = '{12'h805, 1'b0, 1'b0, 14'h0405, 8'h05};
        tbl2k[1] = '{12'h000, 1'b1, 1'b1, 14'h0000, 8'h00};
        tbl2k[2] = '{12'h3FF, 1'b0, 1'b1, 14'h03FF, 8'hFF};
        tbl2k[3] = '{12'h400, 1'b0, 1'b0, 14'h0000, 8'h00};
        tbl2k[4] = '{12'hFFF, 1'b1, 1'b1, 14'h07FF, 8'hFF};
        tbl2k[5] = '{12'h8A3, 1'b0, 1'b0, 14'h04A3, 8'hA3};
        tbl8k[0] = '{12'h0A3, 1'b0, 1'b1, 14'h10A3, 8'hA3};
        tbl8k[1] = '{12'h0A3, 1'b1, 1'b1, 14'h18A3, 8'hA3};
        tbl8k[2] = '{12'hFFF, 1'b1, 1'b1, 14'h1FFF, 8'hFF};
        tbl8k[3] = '{12'h400, 1'b0, 1'b0, 14'h0000, 8'h00};

        for (int i = 0; i < 16384; i++) begin
            mem[i] = 8'h00;
            exp_img[i] = 8'h00;
        end

        // Reset state
        tick();
        tick();
        check("rst_rom_a", 32'(rom_a), 32'h0);
        check("rst_rom_we", 32'(rom_we), 32'h0);
        check("rst_rom_wd", 32'(rom_wd), 32'h0);
        check("rst_cart_d", 32'(cart_d), 32'hFF);
        check("rst_size", 32'(cart_size), 32'h0);
        check("rst_loaded", 32'(loaded), 32'h0);
`ifdef VP_CART_CRC_EN
        check("rst_crc", cart_crc, 32'h0);
`endif
        res_n = 1'b1;
        tick();
        random_fetches(3);

        // 2K image, data = addr[7:0]
        dl_start();
        send_bytes(0, 2048, 1'b0, 1'b0, 1'b0);
        end_dl(1'b0);
        check("size_2k", 32'(cart_size), 32'h0800);
        foreach (tbl2k[i]) fetch(tbl2k[i].a, tbl2k[i].b0, tbl2k[i].b1, tbl2k[i].exp_a, tbl2k[i].exp_d);

        // CRC check string, last byte coincides with dl_active fall
        s9 = "123456789";
        dl_start();
        for (int i = 0; i < 9; i++) send_one(i, s9[i], i == 8, i == 0);
        end_dl(1'b1);
        check("size_9", 32'(cart_size), 32'd9);
`ifdef VP_CART_CRC_EN
        check("crc_123456789", cart_crc, 32'hCBF43926);
`endif
        random_fetches(4);

        // 8K image
        dl_start();
        send_bytes(0, 8192, 1'b0, 1'b0, 1'b0);
        end_dl(1'b0);
        foreach (tbl8k[i]) fetch(tbl8k[i].a, tbl8k[i].b0, tbl8k[i].b1, tbl8k[i].exp_a, tbl8k[i].exp_d);
        random_fetches(10);

        // Exactly 4K, random data with gaps, simultaneous fall
        dl_start();
        send_bytes(0, 4096, 1'b1, 1'b1, 1'b1);
        end_dl(1'b1);
        random_fetches(12);

        // Just over 8K: full 16K mapping
        dl_start();
        send_bytes(0, 8193, 1'b1, 1'b0, 1'b0);
        end_dl(1'b0);
        random_fetches(12);

        // Reset mid-download
        dl_start();
        send_bytes(0, 100, 1'b1, 1'b0, 1'b0);
        tick();
        res_n = 1'b0;
        tick();
        check("midrst_size", 32'(cart_size), 32'h0);
        check("midrst_cart_d", 32'(cart_d), 32'hFF);
        bq.delete();
        exp_writes = 0;
        we_base = we_total;
        bad = loaded_total;
        res_n = 1'b1;
        tick();
        tick();
        send_bytes(0, 50, 1'b1, 1'b0, 1'b0);
        end_dl(1'b0);
        check("midrst_size_50", 32'(cart_size), 32'd50);
        check("midrst_loaded_cnt", 32'(loaded_total - bad), 32'd1);
        random_fetches(4);

        // Oversize image
        dl_start();
        send_bytes(0, 20000, 1'b1, 1'b0, 1'b0);
        end_dl(1'b0);
        check("size_oversize", 32'(cart_size), 32'h4E20);
        bad = 0;
        for (int i = 0; i < 16384; i++)
            if (mem[i] !== exp_img[i]) bad++;
        check("rom_intact", 32'(bad), 32'h0);
        random_fetches(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vp_cart_ctrl.md
# vp_cart_ctrl

Cartridge-side responder for the Videopac console cartridge bus. It owns the cartridge ROM store, writes downloaded images into it, and tracks the image size. It maps the console's program-fetch address and bank-switch lines onto the store, and returns fetched bytes on the cartridge data input. It sits between the loader (ioctl download path), the single-port synchronous cart ROM, and `vp_console`.

## Interface
- `ADDR_W`, 14 — ROM store address width; 16 KB maximum image.
- `clk_i` in 1 — system clock (`clk_sys`).
- `res_n_i` in 1 — reset; asynchronous, active-low.
- `dl_active_i` in 1 — download in progress. Valid only for cart-ROM downloads; the parent pre-qualifies it by index.
- `dl_wr_i` in 1 — download byte strobe, one cycle.
- `dl_addr_i` in 25 — download byte address.
- `dl_data_i` in 8 — download byte.
- `cart_a_i` in 12 — console cart address.
- `cart_bs0_i`, `cart_bs1_i` in 1 each — bank-switch lines.
- `cart_psen_n_i` in 1 — program store enable, active-low.
- `cart_d_o` out 8 — data to the console (`cart_d_i` on the console side).
- `rom_a_o` out ADDR_W — ROM address, registered.
- `rom_we_o` out 1 — ROM write enable, registered.
- `rom_wd_o` out 8 — ROM write data, registered.
- `rom_d_i` in 8 — ROM read data, valid one cycle after `rom_a_o`.
- `cart_size_o` out 16 — size of the last completed image.
- `loaded_o` out 1 — one-cycle pulse when a download completes.
- `cart_crc_o` out 32 — CRC-32 of the last image. Present only with `VP_CART_CRC_EN`.

## Operation
Loader FSM has three states: IDLE, LOAD, DONE.
- **IDLE → LOAD**: on a rising edge of `dl_active_i`. The edge detector register resets to 0. Entry clears the byte counter and sets the CRC to 0xFFFFFFFF.
- **LOAD, per `dl_wr_i`**:
  - Counter increments, saturating at 0xFFFF.
  - If `dl_addr_i` < 2^ADDR_W, drive `rom_a_o`/`rom_wd_o` with the byte and pulse `rom_we_o`. Otherwise count the byte without writing it.
- **LOAD → DONE**: on a falling edge of `dl_active_i`.
- **DONE**: latches the counter into `cart_size_o`, latches the CRC into `cart_crc_o`, pulses `loaded_o`, then returns to IDLE.
- **While in LOAD**: `cart_d_o` is forced to 0xFF and console fetches are ignored.

Mapping is applied outside LOAD and selected by `cart_size_o` (S). The index is truncated to ADDR_W.
- S ≤ 0x0800: {a[11], a[9:0]}.
- 0x0800 < S ≤ 0x1000: {bs0, a[11], a[9:0]}.
- 0x1000 < S ≤ 0x2000: {bs1, bs0, a[11], a[9:0]}.
- S > 0x2000: {bs1, bs0, a[11:0]}.
- S = 0 (nothing loaded) uses the 2K rule.

Read path:
- `cart_d_o` = `rom_d_i` when `cart_psen_n_i`, delayed two cycles, is low.
- Otherwise `cart_d_o` = 0xFF.

## Timing
- **Reset values**:
  - State IDLE, counter 0.
  - `rom_a_o` 0, `rom_we_o` 0, `rom_wd_o` 0.
  - `cart_d_o` 0xFF, `cart_size_o` 0, `loaded_o` 0, `cart_crc_o` 0.
- **Fetch latency** is 3 clk_i edges:
  - Edge 1 registers `rom_a_o`.
  - Edge 2: ROM returns data.
  - Edge 3 registers `cart_d_o`.
  - The CPU enable period is ≥8 clocks, so data is stable before sampling.
- **ROM write**: `rom_we_o` is high exactly one cycle, on the edge after `dl_wr_i`.
- **Back-to-back strobes**: each `dl_wr_i` produces one write and one count, with no gap required.
- **`loaded_o`** goes high one cycle after `dl_active_i` is sampled low.
- **Simultaneous `dl_wr_i` and `dl_active_i` fall**: the byte is counted and written before DONE.
- **Reset mid-download**: returns to IDLE and `cart_size_o` becomes 0. If `dl_active_i` is still high at release, the FSM re-enters LOAD on the next edge and counts only the subsequent bytes.
- **Counter saturation**: the counter holds at 0xFFFF.

## Configuration
- With `VP_CART_CRC_EN`:
  - A byte-serial CRC-32 runs: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, one byte per cycle on `dl_wr_i`.
  - The final XOR with 0xFFFFFFFF is applied at DONE.
  - Bytes beyond 2^ADDR_W are included in the CRC.
- Without it: the `cart_crc_o` port and the CRC logic are absent.

## Structure
- Package `vp_cart_pkg` holds:
  - The FSM state enum.
  - The size thresholds 0x0800, 0x1000, 0x2000.
  - `CRC32_POLY` and `CRC32_INIT`.
- Sub-module `vp_cart_crc32` implements the byte-serial CRC (ports: clear, byte strobe, data, result). It is instantiated only under `VP_CART_CRC_EN`.

## Test plan
- **2K image**: download 2048 bytes, data = addr[7:0]. Expect `cart_size_o` = 0x0800 and a 1-cycle `loaded_o`. Then PSEN low with a = 0x805: `rom_a_o` = 0x405 and `cart_d_o` = 0x05 after 3 edges.
- **8K image**: bs1 = 1, bs0 = 0, a = 0x0A3 → `rom_a_o` = 0x10A3. Toggle bs0 = 1 → `rom_a_o` = 0x18A3.
- **PSEN release**: deassert `cart_psen_n_i` → `cart_d_o` = 0xFF within 3 edges. During any download, `cart_d_o` stays 0xFF regardless of PSEN.
- **CRC**: download ASCII "123456789" → `cart_size_o` = 9 and `cart_crc_o` = 0xCBF43926 (with `VP_CART_CRC_EN`).
- **Reset mid-download**: assert `res_n_i` low after 100 bytes, release with `dl_active_i` still high, send 50 bytes, drop active → `cart_size_o` = 50 and one `loaded_o` pulse.
- **Oversize image**: download 20000 bytes with ADDR_W = 14 → `cart_size_o` = 0x4E20. No `rom_we_o` for dl_addr ≥ 0x4000, and ROM contents at 0x0000–0x3FFF are intact.
